memory_stage: RTL
=================

# memory_stage

Memory stage of the single-cycle (SEQ) Y86-64 processor, directly downstream of the execute stage. Consumes `valE` from execute plus `valA`/`valP` from decode/fetch, performs 8-byte little-endian data-memory reads and writes, and produces `valM` together with the processor status `stat`. It owns the data memory array and a run/stop state machine that freezes architectural memory once a non-AOK status is reached.

## Interface
- `MEM_BYTES`, 1024: data memory size in bytes, power of two, ≥ 8.
- `ADDR_W`, $clog2(MEM_BYTES): internal byte-address width.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `icode` input 4: instruction code of the current instruction.
- `valE` input 64: execute-stage result.
- `valA` input 64: decode-stage operand A.
- `valP` input 64: incremented PC from fetch.
- `instr_valid` input 1: fetch decoded a legal icode/ifun.
- `imem_error` input 1: fetch address out of range.
- `valM` output 64: data read from memory.
- `dmem_error` output 1: current access address is invalid.
- `stat` output 3: status, AOK=1, HLT=2, ADR=3, INS=4.
- `halted` output 1: state machine is in STOPPED.

## Operation
- Icodes: 0 halt, 4 rmmovq, 5 mrmovq, 8 call, 9 ret, A pushq, B popq; all others make no memory access.
- Address: `valE` for 4, 5, 8, A; `valA` for 9, B.
- Write data: `valA` for 4, A; `valP` for 8. Reads: 5, 9, B.
- Access covers bytes addr..addr+7; byte addr+k holds bits [8k+7:8k].
- `valM`: combinational read of the addressed 8 bytes on a read icode with no `dmem_error`; otherwise 0.
- Combinational status priority: `imem_error` → ADR; else `!instr_valid` → INS; else `dmem_error` → ADR; else icode 0 → HLT; else AOK.
- States: RUN, STOPPED.
  - RUN: `stat` = combinational status. On a rising edge with status ≠ AOK, the status is latched into `held_stat` and the state goes to STOPPED.
  - STOPPED: `stat` = `held_stat`, `halted`=1, no writes, `valM`=0. Only `rst` exits.
- A write commits at the rising edge only when in RUN, the icode is a write icode, and the combinational status is AOK.
- Reset values: state RUN, `held_stat` AOK, `halted` 0. `stat` is then combinational. Memory contents are not cleared by reset.

## Timing
- Read latency 0: `valM` and `dmem_error` are valid in the same cycle as their inputs.
- Write is visible to a read in the cycle after its commit edge.
- Store followed by load to the same address in consecutive cycles returns the new data.
- Transition to STOPPED happens at the edge that samples a non-AOK status. The faulting instruction's write is suppressed.
- `rst` asserted asynchronously: the state returns to RUN immediately. A write coinciding with the reset edge is dropped.
- Address arithmetic uses the full 64 bits. No wrap inside the 8-byte window when bounds checking is on.

## Configuration
- `DMEM_BOUNDS_CHECK_EN` defined: `dmem_error`=1 when any access byte is ≥ `MEM_BYTES`, i.e. addr > `MEM_BYTES`-8, checked on the 64-bit address.
- Not defined: `dmem_error` is tied 0. Each byte address is taken modulo `MEM_BYTES`, so the 8 bytes may wrap to address 0.

## Structure
- Shared package `y86_pkg`: icode constants (IHALT…IPOPQ), stat codes (SAOK, SHLT, SADR, SINS), and the run/stop state enum.
- One sub-module `data_mem`: a byte array with an 8-byte combinational read port and an 8-byte synchronous write port with enable. It is parameterised by `MEM_BYTES` and performs no status logic.

## Test plan
- Store then load: rmmovq with `valE`=0x40, `valA`=0x1122334455667788, then mrmovq with `valE`=0x40. Expect `valM`=0x1122334455667788 and byte 0x40 = 0x88.
- Push then pop: pushq with `valE`=0x100, `valA`=5, then popq with `valA`=0x100. Expect `valM`=5. Call with `valE`=0x80, `valP`=0x2A, then ret with `valA`=0x80. Expect `valM`=0x2A.
- Bounds with macro on: rmmovq with `valE`=`MEM_BYTES`-4. Expect `dmem_error`=1 and `stat`=ADR, `halted`=1 next cycle, and memory unchanged. Without the macro, the same access wraps and bytes 0..3 are written.
- Halt: icode 0 → `stat`=HLT. A following rmmovq writes nothing, `stat` stays HLT and `valM`=0.
- Priority: `imem_error`=1 together with `instr_valid`=0 → `stat`=ADR. `instr_valid`=0 alone → INS.
- Reset mid-run: assert `rst` while STOPPED and between edges. `halted` drops immediately, `stat` is AOK for a nop, and earlier memory contents are preserved.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes and the
// memory-stage run/stop state encoding.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef enum logic {
        S_RUN     = 1'b0,
        S_STOPPED = 1'b1
    } run_state_e;

endpackage

// File: rtl/data_mem.sv
// Byte-addressed data memory: 8-byte little-endian combinational read and
// 8-byte synchronous write. Byte addresses wrap modulo MEM_BYTES.
// Ports: clk, i_addr (byte address), i_we, i_wdata, o_rdata.
module data_mem #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_we,
    input  logic [63:0]       i_wdata,
    output logic [63:0]       o_rdata
);

    logic [7:0] r_mem [MEM_BYTES];

    always_comb begin
        o_rdata = '0;
        for (int k = 0; k < 8; k++) begin
            o_rdata[8*k +: 8] = r_mem[i_addr + ADDR_W'(k)];
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int k = 0; k < 8; k++) begin
                r_mem[i_addr + ADDR_W'(k)] <= i_wdata[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/memory_stage.sv
// SEQ Y86-64 memory stage: data memory access, valM and processor status
// with a run/stop machine that freezes memory after a non-AOK status.
// Ports: clk, rst, icode, valE, valA, valP, instr_valid, imem_error in;
//        valM, dmem_error, stat, halted out.
// Optional: DMEM_BOUNDS_CHECK_EN enables out-of-range address detection.
module memory_stage
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    input  logic        instr_valid,
    input  logic        imem_error,
    output logic [63:0] valM,
    output logic        dmem_error,
    output logic [2:0]  stat,
    output logic        halted
);

    run_state_e  r_state;
    run_state_e  w_state_nxt;
    logic [2:0]  r_held_stat;
    logic [2:0]  w_held_nxt;

    logic [63:0] w_addr;
    logic [63:0] w_wdata;
    logic [63:0] w_rdata;
    logic        w_is_rd;
    logic        w_is_wr;
    logic        w_dmem_error;
    logic [2:0]  w_cstat;
    logic        w_we;
    logic        w_unused_addr_hi;

    always_comb begin
        w_addr  = valE;
        w_wdata = '0;
        w_is_rd = 1'b0;
        w_is_wr = 1'b0;
        case (icode)
            IRMMOVQ: begin
                w_is_wr = 1'b1;
                w_wdata = valA;
            end
            IMRMOVQ: w_is_rd = 1'b1;
            ICALL: begin
                w_is_wr = 1'b1;
                w_wdata = valP;
            end
            IRET: begin
                w_addr  = valA;
                w_is_rd = 1'b1;
            end
            IPUSHQ: begin
                w_is_wr = 1'b1;
                w_wdata = valA;
            end
            IPOPQ: begin
                w_addr  = valA;
                w_is_rd = 1'b1;
            end
            default: ;
        endcase
    end

    // Upper address bits only matter to the bounds check.
    assign w_unused_addr_hi = ^w_addr[63:ADDR_W];

`ifdef DMEM_BOUNDS_CHECK_EN
    // Full 64-bit compare: any byte of the 8-byte window past the end.
    assign w_dmem_error = (w_is_rd | w_is_wr)
                        && (w_addr > 64'(MEM_BYTES - 8));
`else
    assign w_dmem_error = 1'b0;
`endif

    always_comb begin
        if (imem_error)        w_cstat = SADR;
        else if (!instr_valid) w_cstat = SINS;
        else if (w_dmem_error) w_cstat = SADR;
        else if (icode == IHALT) w_cstat = SHLT;
        else                   w_cstat = SAOK;
    end

    // rst gates the enable so a write at a reset edge is dropped.
    assign w_we = (r_state == S_RUN) && w_is_wr
                && (w_cstat == SAOK) && !rst;

    data_mem #(
        .MEM_BYTES(MEM_BYTES),
        .ADDR_W   (ADDR_W)
    ) u_mem (
        .clk    (clk),
        .i_addr (w_addr[ADDR_W-1:0]),
        .i_we   (w_we),
        .i_wdata(w_wdata),
        .o_rdata(w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_held_stat <= SAOK;
        end else begin
            r_state     <= w_state_nxt;
            r_held_stat <= w_held_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_held_nxt  = r_held_stat;
        stat        = r_held_stat;
        halted      = 1'b0;
        valM        = '0;
        case (r_state)
            S_RUN: begin
                stat = w_cstat;
                if (w_is_rd && !w_dmem_error) valM = w_rdata;
                if (w_cstat != SAOK) begin
                    w_state_nxt = S_STOPPED;
                    w_held_nxt  = w_cstat;
                end
            end
            S_STOPPED: halted = 1'b1;
            default: ;
        endcase
    end

    assign dmem_error = w_dmem_error;

endmodule
